// File: rtl/clk_div_ctrl_if.sv
// Ratio-request handshake between config/CSR logic and clk_div_ctrl.
// master = requester, slave = divider controller.
interface clk_div_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             div_req_valid;
   logic [CNT_W:0]   div_req_ratio;
   logic             div_req_ready;
   logic             div_err;

   modport master (
      output div_req_valid,
      output div_req_ratio,
      input  div_req_ready,
      input  div_err
   );

   modport slave (
      input  div_req_valid,
      input  div_req_ratio,
      output div_req_ready,
      output div_err
   );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the divided clock; ratio changes and stops
// land on period boundaries. Optional macro: CLK_DIV_CTRL_ODD_EN.
module clk_div_ctrl #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   clk_div_ctrl_if.slave  req,
   output logic           clk_div,
   output logic           div_active,
   output logic [CNT_W:0] cur_ratio
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PEND
   } state_t;

   localparam logic [CNT_W:0] DEF_R = (CNT_W+1)'(DEF_DIV);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   shadow_q, shadow_d;
   logic [CNT_W:0]   ratio_d;
   logic             clk_d;
   logic             err_q, err_d;
   logic             active_d;

   logic [CNT_W:0]   r;
   logic             legal;
   logic             ready;
   logic             acc;
   logic [CNT_W-1:0] hi_lim;
   logic [CNT_W-1:0] lo_lim;
   logic [CNT_W-1:0] lim;
   logic             wrap;
   logic             pb;

   assign r      = req.div_req_ratio;
   assign hi_lim = cur_ratio[CNT_W:1] - {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef CLK_DIV_CTRL_ODD_EN
   // odd N: low phase gets the extra cycle; all-ones would overflow cnt
   assign legal  = (r[CNT_W:1] != '0) && (r != '1);
   assign lo_lim = cur_ratio[CNT_W:1]
                 - {{(CNT_W-1){1'b0}}, ~cur_ratio[0]};
`else
   assign legal  = (r[CNT_W:1] != '0) && !r[0];
   assign lo_lim = hi_lim;
`endif

   assign ready = (state_q != PEND);
   assign acc   = req.div_req_valid && ready;
   assign lim   = clk_div ? hi_lim : lo_lim;
   assign wrap  = (cnt_q == lim);
   assign pb    = clk_div && wrap;

   assign req.div_req_ready = ready;
   assign req.div_err       = err_q;

   // next-state, counter and output decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clk_d    = clk_div;
      ratio_d  = cur_ratio;
      shadow_d = shadow_q;
      err_d    = acc && !legal;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (acc && legal) ratio_d = r;
            if (en) state_d = RUN;
         end
         RUN: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            clk_d = wrap ? ~clk_div : clk_div;
            if (pb && !en) begin
               state_d = IDLE;
               if (acc && legal) ratio_d = r;
            end else if (acc && legal) begin
               state_d  = PEND;
               shadow_d = r;
            end
         end
         PEND: begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            clk_d = wrap ? ~clk_div : clk_div;
            if (pb) begin
               ratio_d = shadow_q;
               state_d = en ? RUN : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      active_d = (state_d != IDLE);
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         clk_div    <= 1'b0;
         cur_ratio  <= DEF_R;
         shadow_q   <= DEF_R;
         err_q      <= 1'b0;
         div_active <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clk_div    <= clk_d;
         cur_ratio  <= ratio_d;
         shadow_q   <= shadow_d;
         err_q      <= err_d;
         div_active <= active_d;
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table, corner sequences,
// and randomized traffic against a period-position reference model.
module tb_clk_div_ctrl;

`ifdef CLK_DIV_CTRL_ODD_EN
   localparam bit ODD = 1'b1;
`else
   localparam bit ODD = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       en;
   logic       clk_div;
   logic       div_active;
   logic [8:0] cur_ratio;

   clk_div_ctrl_if #(.CNT_W(8)) bus ();

   clk_div_ctrl #(
      .CNT_W   (8),
      .DEF_DIV (6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req        (bus),
      .clk_div    (clk_div),
      .div_active (div_active),
      .cur_ratio  (cur_ratio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // reference model: position inside the current period
   int m_run, m_pend, m_ratio, m_shadow, m_pos, m_err;

   function automatic bit legal_r(int n);
      return (n >= 2) && (n <= 510) && (ODD || (n % 2 == 0));
   endfunction

   task automatic m_step(bit r, bit e, bit v, int n);
      bit acc, lg, pb;
      if (r) begin
         m_run = 0; m_pend = 0; m_ratio = 6;
         m_shadow = 6; m_pos = 0; m_err = 0;
         return;
      end
      acc   = v && !m_pend;
      lg    = legal_r(n);
      m_err = acc && !lg;
      if (!m_run) begin
         if (acc && lg) m_ratio = n;
         if (e) begin
            m_run = 1;
            m_pos = 0;
         end
      end else begin
         pb = (m_pos == m_ratio - 1);
         if (pb) begin
            m_pos = 0;
            if (m_pend) begin
               m_ratio = m_shadow;
               m_pend  = 0;
            end
            if (!e) m_run = 0;
         end else begin
            m_pos++;
         end
         if (acc && lg) begin
            if (!m_run) begin
               m_ratio = n;
            end else begin
               m_pend   = 1;
               m_shadow = n;
            end
         end
      end
   endtask

   task automatic chk(string nm, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0d, expected %0d",
                  nm, cyc, act, exp);
      end
   endtask

   task automatic cycle(bit r, bit e, bit v, int n);
      rst               = r;
      en                = e;
      bus.div_req_valid = v;
      bus.div_req_ratio = 9'(n);
      @(posedge clk);
      m_step(r, e, v, n);
      cyc++;
      #1;
   endtask

   task automatic chk_model();
      int ec;
      ec = (m_run != 0) && (m_pos >= (m_ratio + 1) / 2);
      chk("m_clk", int'(clk_div), ec);
      chk("m_act", int'(div_active), m_run);
      chk("m_rdy", int'(bus.div_req_ready), int'(m_pend == 0));
      chk("m_err", int'(bus.div_err), m_err);
      chk("m_cur", int'(cur_ratio), m_ratio);
   endtask

   typedef struct {
      bit rst, en, valid;
      int ratio;
      bit clk, act, rdy, err;
      int cur;
   } vec_t;

   vec_t tq[$];

   function automatic void add(bit r, bit e, bit v, int n,
                               bit c, bit a, bit rd, bit er,
                               int cr);
      vec_t t;
      t.rst = r; t.en = e; t.valid = v; t.ratio = n;
      t.clk = c; t.act = a; t.rdy = rd; t.err = er;
      t.cur = cr;
      tq.push_back(t);
   endfunction

   initial begin
      int exp_c[4];
      rst = 1'b1;
      en  = 1'b0;
      bus.div_req_valid = 1'b0;
      bus.div_req_ratio = '0;
      m_run = 0; m_pend = 0; m_ratio = 6;
      m_shadow = 6; m_pos = 0; m_err = 0;
      @(negedge clk);

      // reset, start at N=6, N=5 request
      add(1,0,0,0, 0,0,1,0,6);
      add(1,0,0,0, 0,0,1,0,6);
      add(0,1,0,0, 0,1,1,0,6);
      add(0,1,0,0, 0,1,1,0,6);
      add(0,1,0,0, 0,1,1,0,6);
      add(0,1,0,0, 1,1,1,0,6);
      add(0,1,0,0, 1,1,1,0,6);
      add(0,1,0,0, 1,1,1,0,6);
      add(0,1,0,0, 0,1,1,0,6);
      add(0,1,1,5, 0,1,!ODD,!ODD,6);
      add(0,1,0,0, 0,1,!ODD,0,6);
      add(0,1,0,0, 1,1,!ODD,0,6);
      add(0,1,0,0, 1,1,!ODD,0,6);
      add(0,1,0,0, 1,1,!ODD,0,6);
      add(0,1,0,0, 0,1,1,0,ODD ? 5 : 6);
      // start with N=2 from IDLE, then N=8, reset in high
      add(1,0,0,0, 0,0,1,0,6);
      add(0,1,1,2, 0,1,1,0,2);
      add(0,1,0,0, 1,1,1,0,2);
      add(0,1,0,0, 0,1,1,0,2);
      add(0,1,0,0, 1,1,1,0,2);
      add(0,1,1,8, 0,1,0,0,2);
      add(0,1,0,0, 1,1,0,0,2);
      add(0,1,0,0, 0,1,1,0,8);
      add(0,1,0,0, 0,1,1,0,8);
      add(0,1,0,0, 0,1,1,0,8);
      add(0,1,0,0, 0,1,1,0,8);
      add(0,1,0,0, 1,1,1,0,8);
      add(0,1,0,0, 1,1,1,0,8);
      add(1,1,0,0, 0,0,1,0,6);

      foreach (tq[i]) begin
         cycle(tq[i].rst, tq[i].en, tq[i].valid, tq[i].ratio);
         chk("t_clk", int'(clk_div), int'(tq[i].clk));
         chk("t_act", int'(div_active), int'(tq[i].act));
         chk("t_rdy", int'(bus.div_req_ready), int'(tq[i].rdy));
         chk("t_err", int'(bus.div_err), int'(tq[i].err));
         chk("t_cur", int'(cur_ratio), tq[i].cur);
      end

      // N=6 -> N=4 requested mid high phase
      cycle(1,0,0,0);
      cycle(0,1,0,0);
      for (int i = 0; i < 4; i++) cycle(0,1,0,0);
      chk("s2_hi", int'(clk_div), 1);
      cycle(0,1,1,4);
      chk("s2_rdy0", int'(bus.div_req_ready), 0);
      chk("s2_cur6", int'(cur_ratio), 6);
      cycle(0,1,0,0);
      chk("s2_cur4", int'(cur_ratio), 4);
      chk("s2_rdy1", int'(bus.div_req_ready), 1);
      exp_c = '{0, 0, 1, 1};
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cycle(0,1,0,0);
         chk("s2_per", int'(clk_div), exp_c[i]);
      end

      // en drops two cycles into the low phase
      cycle(1,0,0,0);
      cycle(0,1,0,0);
      cycle(0,1,0,0);
      for (int i = 0; i < 5; i++) begin
         cycle(0,0,0,0);
         chk("s4_clk", int'(clk_div), int'(i inside {[1:3]}));
         chk("s4_act", int'(div_active), int'(i < 4));
      end
      cycle(0,0,0,0);
      chk("s4_idle", int'(clk_div), 0);
      chk("s4_iact", int'(div_active), 0);

      // randomized traffic against the model
      begin
         bit e;
         bit v;
         bit r;
         int n;
         e = 1'b1;
         for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) e = !e;
            v = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0)
               n = $urandom_range(0, 511);
            else
               n = $urandom_range(0, 12);
            cycle(r, e, v, n);
            chk_model();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
